// File: rtl/inst_buffer_pkg.sv
// Shared core constants for the fetch-to-decode instruction buffer.
package inst_buffer_pkg;

  localparam int IB_DEPTH = 4;
  localparam int INST_W   = 32;
  localparam int PC_W     = 32;

  // LoongArch canonical NOP: andi r0, r0, 0
  localparam logic [INST_W-1:0] NOP_INST = 32'h0340_0000;

endpackage

// File: rtl/inst_buffer.sv
// Circular instruction buffer between fetch check and decode.
// Three flush sources share one discard path; storage is a plain register array.
module inst_buffer
  import inst_buffer_pkg::*;
#(
  parameter int DEPTH = IB_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       excp_flush,
  input  logic                       ertn_flush,
  input  logic [INST_W-1:0]          in_inst,
  input  logic [PC_W-1:0]            in_pc,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic                       in_fire,
  output logic [INST_W-1:0]          out_inst,
  output logic [PC_W-1:0]            out_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [PC_W-1:0]   pc_mem   [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              anyflush;
  logic              push;
  logic              pop;

  assign anyflush  = flush | excp_flush | ertn_flush;
  // Full means not ready even if decode pops this cycle: no pass-through
  assign in_ready  = !reset && !anyflush && (count != FULL_CNT);
  assign in_fire   = in_valid & in_ready;
  assign out_valid = (count != '0) && !anyflush;
  assign out_inst  = inst_mem[rd_ptr];
  assign out_pc    = pc_mem[rd_ptr];
  assign push      = in_fire;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        inst_mem[i] <= '0;
        pc_mem[i]   <= '0;
      end
    end else if (anyflush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        inst_mem[wr_ptr] <= in_inst;
        pc_mem[wr_ptr]   <= in_pc;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_buffer.sv
// Bench for inst_buffer: directed scenarios then random traffic against a queue model.
module tb_inst_buffer;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        excp_flush;
  logic        ertn_flush;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        in_valid;
  logic        in_ready;
  logic        in_fire;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  count;

  int tests = 0;
  int fails = 0;

  // Reference: queue of {pc, inst} in acceptance order
  logic [63:0] q[$];
  bit          mem_zero;

  inst_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush), .excp_flush(excp_flush),
    .ertn_flush(ertn_flush), .in_inst(in_inst), .in_pc(in_pc),
    .in_valid(in_valid), .in_ready(in_ready), .in_fire(in_fire),
    .out_inst(out_inst), .out_pc(out_pc), .out_valid(out_valid),
    .out_ready(out_ready), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: apply inputs, check combinational view against the model, then advance the model
  task automatic step(input logic r, input logic v, input logic rd, input logic f,
                      input logic ef, input logic erf, input logic [31:0] pc,
                      input logic [31:0] inst);
    logic any, exp_ready, exp_fire, exp_ov;
    @(negedge clk);
    reset = r; in_valid = v; out_ready = rd; flush = f; excp_flush = ef;
    ertn_flush = erf; in_pc = pc; in_inst = inst;
    #1;
    any       = f | ef | erf;
    exp_ready = !r && !any && (q.size() != DEPTH);
    exp_fire  = v && exp_ready;
    exp_ov    = (q.size() != 0) && !any;
    chk("in_ready", 32'(in_ready), 32'(exp_ready));
    chk("in_fire", 32'(in_fire), 32'(exp_fire));
    chk("out_valid", 32'(out_valid), 32'(exp_ov));
    chk("count", 32'(count), q.size());
    if (exp_ov) begin
      chk("out_pc", out_pc, q[0][63:32]);
      chk("out_inst", out_inst, q[0][31:0]);
    end
    if (mem_zero) begin
      chk("out_pc_zero", out_pc, 32'h0);
      chk("out_inst_zero", out_inst, 32'h0);
    end
    @(posedge clk);
    if (r) begin
      q.delete();
      mem_zero = 1'b1;
    end else if (any) begin
      q.delete();
    end else begin
      if (exp_ov && rd) void'(q.pop_front());
      if (exp_fire) begin
        q.push_back({pc, inst});
        mem_zero = 1'b0;
      end
    end
  endtask

  initial begin
    logic [31:0] pc_ctr;
    reset = 1'b1; flush = 1'b0; excp_flush = 1'b0; ertn_flush = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; in_pc = '0; in_inst = '0;
    mem_zero = 1'b1;
    repeat (2) @(posedge clk);

    // Reset held with traffic offered
    step(1, 1, 1, 0, 0, 0, 32'h1C00_0000, 32'h1);
    step(1, 1, 0, 0, 0, 0, 32'h1C00_0004, 32'h2);

    // Fill to full with decode stalled
    for (int i = 0; i < 4; i++)
      step(0, 1, 0, 0, 0, 0, 32'h1C00_0000 + 32'(4 * i), 32'hA + 32'(i));
    // Full: pop only, offered push refused; then push accepted
    step(0, 1, 1, 0, 0, 0, 32'h1C00_0010, 32'hE);
    step(0, 1, 0, 0, 0, 0, 32'h1C00_0010, 32'hE);
    step(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);

    // Flush, then single push into empty: visible only next cycle
    step(0, 0, 0, 1, 0, 0, 32'h0, 32'h0);
    step(0, 1, 0, 0, 0, 0, 32'h1C00_0040, 32'h40);
    step(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    step(0, 0, 1, 0, 0, 0, 32'h0, 32'h0);

    // Streaming through the pointer wrap
    for (int i = 0; i < 20; i++)
      step(0, 1, 1, 0, 0, 0, 32'h1C00_0100 + 32'(4 * i), 32'h100 + 32'(i));
    step(0, 0, 1, 0, 0, 0, 32'h0, 32'h0);

    // Three entries then exception flush with handshake offered both sides
    for (int i = 0; i < 3; i++)
      step(0, 1, 0, 0, 0, 0, 32'h1C00_0200 + 32'(4 * i), 32'h200 + 32'(i));
    step(0, 1, 1, 0, 1, 0, 32'h1C00_020C, 32'h203);
    for (int i = 0; i < 6; i++)
      step(0, 1, 1, 0, 0, 0, 32'h1C00_0300 + 32'(4 * i), 32'h300 + 32'(i));
    step(0, 0, 1, 0, 0, 1, 32'h0, 32'h0);

    // Two entries then reset mid-operation
    step(0, 1, 0, 0, 0, 0, 32'h1C00_0400, 32'h400);
    step(0, 1, 0, 0, 0, 0, 32'h1C00_0404, 32'h401);
    step(1, 1, 1, 0, 0, 0, 32'h1C00_0408, 32'h402);
    step(1, 1, 1, 0, 0, 0, 32'h1C00_040C, 32'h403);
    step(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);

    // Random traffic
    pc_ctr = 32'h1C00_1000;
    for (int i = 0; i < 400; i++) begin
      logic r, v, rd, f, ef, erf;
      r   = ($urandom_range(0, 59) == 0);
      f   = ($urandom_range(0, 24) == 0);
      ef  = ($urandom_range(0, 29) == 0);
      erf = ($urandom_range(0, 29) == 0);
      v   = ($urandom_range(0, 3) != 0);
      rd  = ($urandom_range(0, 2) != 0);
      step(r, v, rd, f, ef, erf, pc_ctr, $urandom);
      pc_ctr = pc_ctr + 32'd4;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/inst_buffer.md
INST_BUFFER -- requirements
Module: inst_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of buffered fetch entries (power of two, >= 2).
REQ-002 SHALL have port clk  input  1  clock; all state SHALL change on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port flush  input  1  pipeline redirect flush.
REQ-005 SHALL have port excp_flush  input  1  exception flush.
REQ-006 SHALL have port ertn_flush  input  1  exception-return flush.
REQ-007 SHALL have port in_inst  input  32  instruction word from fetch check stage.
REQ-008 SHALL have port in_pc  input  32  virtual PC of in_inst.
REQ-009 SHALL have port in_valid  input  1  in_inst/in_pc valid.
REQ-010 SHALL have port in_ready  output  1  buffer can accept an entry this cycle.
REQ-011 SHALL have port in_fire  output  1  pulse: entry consumed from fetch this cycle.
REQ-012 SHALL have port out_inst  output  32  head instruction to decode.
REQ-013 SHALL have port out_pc  output  32  head PC to decode.
REQ-014 SHALL have port out_valid  output  1  head entry valid.
REQ-015 SHALL have port out_ready  input  1  decode accepts head entry.
REQ-016 SHALL have port count  output  clog2(DEPTH)+1  number of occupied entries.

Function
REQ-017 SHALL be a circular FIFO: write pointer, read pointer (clog2(DEPTH) bits each, natural wrap DEPTH-1 -> 0), occupancy counter.
REQ-018 SHALL drive in_ready = !reset & !anyflush & (count != DEPTH), anyflush = flush|excp_flush|ertn_flush; no pass-through of same-cycle pop when full.
REQ-019 SHALL drive in_fire = in_valid & in_ready; push occurs exactly when in_fire = 1.
REQ-020 SHALL drive out_valid = (count != 0) & !anyflush.
REQ-021 SHALL drive out_inst/out_pc combinationally from the entry at the read pointer; pop occurs when out_valid & out_ready.
REQ-022 SHALL have 1-cycle latency: entry pushed at edge N appears on out_* in the cycle after edge N; no in->out bypass when empty.
REQ-023 SHALL on simultaneous push and pop keep count unchanged and advance both pointers.
REQ-024 SHALL when full ignore in_valid (in_ready = 0); when empty ignore out_ready (out_valid = 0).
REQ-025 SHALL keep count within 0..DEPTH at all times; overflow/underflow SHALL be impossible by construction.
REQ-026 SHALL when anyflush = 1 at an edge set count and both pointers to 0, discarding any same-cycle push and pop.
REQ-027 SHALL treat all three flush inputs identically; flush priority SHALL be below reset only.
REQ-028 SHALL preserve FIFO order: out_pc sequence equals accepted in_pc sequence between flushes.

Reset
REQ-029 SHALL on reset set count = 0, read/write pointers = 0, all storage entries = 0.
REQ-030 SHALL present during and after reset: out_valid = 0, out_inst = 0, out_pc = 0, in_ready = 0 while reset high, in_ready = 1 first cycle after reset low, in_fire = 0, count = 0.
REQ-031 SHALL treat reset mid-operation as a full discard, identical to REQ-029, regardless of handshake state.

Structure
REQ-032 SHALL take DEPTH default, instruction width (32), PC width (32) and NOP encoding constants from the shared core package.
REQ-033 SHALL be a single module; storage SHALL be a register array (no sub-module, no SRAM macro).

Verification
REQ-034 Reset then push pc 0x1C000000..0x1C00000C inst 0xA..0xD, out_ready = 0 -> count = 4, in_ready = 0, out_pc = 0x1C000000.
REQ-035 Full buffer, in_valid = 1, out_ready = 1 one cycle -> pop 0x1C000000, no push that cycle (in_fire = 0), count = 3, next cycle push accepted.
REQ-036 Continuous in_valid = out_ready = 1 for 20 cycles from empty -> steady count = 1, one entry out per cycle, order preserved across pointer wrap.
REQ-037 count = 3, excp_flush pulse with in_valid = out_ready = 1 -> next cycle count = 0, out_valid = 0, in_fire = 0 in flush cycle, no entry lost or duplicated afterwards.
REQ-038 Empty buffer, single push 0x1C000040 -> out_valid = 0 same cycle, out_valid = 1 with out_pc = 0x1C000040 next cycle.
REQ-039 Reset asserted with count = 2 -> following cycle count = 0, out_inst = 0, out_pc = 0, in_ready = 0 while reset high.
